bus_a_rr_arbiter: RTL
=====================

Name: bus_a_rr_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the 32-bit bus_A datapath input of TOP between NREQ requesters.
- Grants the bus for one burst at a time, muxes the owner's data onto bus_A and counts beats.
- Releases the bus on last beat, burst limit or request withdrawal, then inserts one turnaround cycle.
- Sits directly in front of TOP's bus_A port; downstream acceptance is signalled by ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width of bus_A.
- MAX_BURST, 8, maximum beats per grant (1..255).
- TIMEOUT, 16, stall cycles before forced release (used only with ARB_TIMEOUT_EN).

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- req, input, NREQ, per-requester bus request (level).
- valid_in, input, NREQ, per-requester data valid.
- last_in, input, NREQ, per-requester last-beat flag, qualified by valid_in.
- data_in, input, NREQ*DW, packed requester data; requester i uses bits [i*DW +: DW].
- ready, input, 1, downstream accepts the current beat.
- gnt, output, NREQ, one-hot grant.
- bus_A, output, DW, muxed data toward TOP.
- bus_valid, output, 1, bus_A holds a valid beat.
- owner, output, 3, index of the current owner.
- busy, output, 1, high in GRANT and RELEASE.
- timeout_err, output, 1, one-cycle pulse on forced release.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gnt=0, owner=0, beat_cnt=0, busy=0, timeout_err=0.
  - rr_ptr=0; bus_A=0, bus_valid=0.
- Arbitration uses three states: IDLE, GRANT, RELEASE.
- IDLE, when any req bit is set:
  - Select the first set req[i] searching from rr_ptr upward, with wrap from NREQ-1 to 0.
  - Register owner=i and gnt=one-hot(i), then enter GRANT.
  - Latency is 1 cycle from req to gnt.
  - If no req bit is set, stay in IDLE.
- GRANT outputs (combinational from the owner register):
  - bus_A = data_in[owner]; bus_valid = valid_in[owner].
- GRANT beat handling:
  - A beat is accepted when bus_valid and ready are both high.
  - Each accepted beat increments beat_cnt (8 bits).
- GRANT release conditions, in priority order:
  1. Accepted beat with last_in[owner]=1.
  2. Accepted beat with beat_cnt==MAX_BURST-1.
  3. req[owner]=0 with no beat accepted this cycle.
- If req[owner] drops in the same cycle a beat is accepted, the beat counts and release still occurs.
- On release:
  - Next state is RELEASE.
  - gnt, bus_valid and bus_A go to 0 from the next cycle.
  - rr_ptr = (owner+1) mod NREQ; beat_cnt=0.
- RELEASE:
  - Exactly one dead cycle with no grant, then return to IDLE.
  - Minimum spacing between bursts is therefore 2 cycles from release to the next gnt.
- Outside GRANT: bus_A=0 and bus_valid=0. Non-owner valid_in is ignored.
- Reset asserted mid-burst aborts immediately; the beat in flight is lost and all outputs take their reset values.
- An owner that never raises valid_in holds the bus indefinitely unless ARB_TIMEOUT_EN is defined.
- Fairness: every requester holding req high is granted within NREQ bursts.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A stall counter is cleared on entry to GRANT and on every accepted beat.
  - It increments while in GRANT with no beat accepted.
  - When it reaches TIMEOUT-1, force release exactly as in release condition 3 and pulse timeout_err for 1 cycle.
- When undefined: no stall counter exists and timeout_err is tied to 0.

Test Plan:
- Reset then single requester: req=4'b0001, valid_in held high, ready=1, data 32'h5D2C_31D0, last_in on the 3rd beat.
  -> gnt=0001 one cycle after req; 3 beats on bus_A; gnt=0 the next cycle; one RELEASE cycle; owner=0.
- All four requesting continuously, each burst 1 beat with last_in=1.
  -> grant order 0,1,2,3,0; gnt high every 3rd cycle; no requester skipped.
- Burst limit: MAX_BURST=8, requester 2 streams 12 beats without last_in, ready=1.
  -> release after the 8th beat, beat_cnt back to 0, requester 2 re-granted only after the others are served.
- Backpressure: ready toggles 1,0,0,1 during a 2-beat burst.
  -> bus_A holds its value while ready=0; exactly 2 beats accepted; release after the 2nd acceptance.
- Request withdrawal and reset: drop req[1] mid-burst with valid_in=0 -> release next cycle.
  Then pull reset low mid-burst -> gnt=0, bus_valid=0 and owner=0 immediately, asynchronously.
- ARB_TIMEOUT_EN, TIMEOUT=16: owner 3 granted with valid_in=0.
  -> forced release after 16 GRANT cycles, timeout_err pulses for 1 cycle, next grant goes to requester 0 if requesting.

Source files
------------

// File: rtl/bus_a_rr_arbiter.sv
// Round-robin arbiter/sequencer that shares the bus_A datapath among NREQ requesters.
// Optional stall timeout is enabled by defining ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner, searching req from rr_ptr upward
// GRANT   | owner drives bus_A, beats counted until release
// RELEASE | single dead turnaround cycle, then back to IDLE
module bus_a_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      valid_in,
  input  logic [NREQ-1:0]      last_in,
  input  logic [NREQ*DW-1:0]   data_in,
  input  logic                 ready,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        bus_A,
  output logic                 bus_valid,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;

  logic              own_req, own_valid, own_last;
  logic [DW-1:0]     own_data;
  logic [2*NREQ-1:0] req_rot;
  logic              found;
  logic [2:0]        sel_idx;
  logic              accept;
  logic              stall_hit;
  logic              release_w;

  // Owner-indexed views of the per-requester inputs
  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req   = req[i];
        own_valid = valid_in[i];
        own_last  = last_in[i];
        own_data  = data_in[i*DW +: DW];
      end
    end
  end

  // Rotate req so bit 0 is the requester at rr_ptr; first set bit wins
  always_comb begin
    int sum;
    sum     = 0;
    found   = 1'b0;
    sel_idx = '0;
    req_rot = {req, req} >> rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr_q) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        sel_idx = 3'(sum);
      end
    end
  end

  assign accept = (state_q == ST_GRANT) && own_valid && ready;

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  assign stall_hit = (state_q == ST_GRANT) && !accept && (stall_cnt_q == SW'(TIMEOUT - 1));

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
    if (state_q != ST_GRANT || accept) begin
      stall_cnt_d = '0;
    end else if (stall_hit) begin
      stall_cnt_d   = '0;
      timeout_err_d = 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A beat accepted while req drops still counts; the missing req then releases
  assign release_w = (state_q == ST_GRANT) &&
                     ((accept && (own_last || beat_cnt_q == 8'(MAX_BURST - 1))) ||
                      !own_req || stall_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          owner_d    = sel_idx;
          beat_cnt_d = '0;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (sel_idx == 3'(i));
        end
      end
      ST_GRANT: begin
        if (accept) beat_cnt_d = beat_cnt_q + 8'd1;
        if (release_w) begin
          state_d    = ST_RELEASE;
          gnt_d      = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus_A     = '0;
    bus_valid = 1'b0;
    if (state_q == ST_GRANT) begin
      bus_A     = own_data;
      bus_valid = own_valid;
    end
    busy  = (state_q != ST_IDLE);
    gnt   = gnt_q;
    owner = owner_q;
  end

endmodule
